execute_stage: RTL and testbench
================================

// Module: execute_stage
// PURPOSE
//  EX stage of the 5-stage RV32IM pipeline; sits directly upstream of the memory stage and owns the EX/MEM register.
//  Computes RV32I ALU results, PC+imm and single-cycle MUL*, and runs an iterative DIV/DIVU/REM/REMU unit.
//  While a divide is in progress it stalls ID/EX (busyE) and sends bubbles into MEM.
// PARAMETERS
//  DIV_BITS_PER_CYCLE  1   quotient bits retired per iteration; legal values 1, 2, 4; N_ITER = 32/DIV_BITS_PER_CYCLE
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   reset, synchronous, active-low
//  validE      in   1   ID/EX holds a real instruction
//  flushE      in   1   kill the EX instruction (branch redirect)
//  ALUCtrlE    in   5   operation code, encoding in BEHAVIOUR
//  srcAE       in   32  operand A (forwarded rs1 or PC)
//  srcBE       in   32  operand B (forwarded rs2 or imm)
//  r2E         in   32  forwarded rs2, used as store data
//  PCE, ImmE   in   32  PC and immediate of the instruction
//  rdE         in   5   destination register
//  strCtrlE    in   3   funct3 for load/store
//  RegWriteE, MemWriteE, MemtoRegE  in 1  control bits
//  busyE       out  1   stall request to the hazard unit; ID/EX holds while it is 1
//  ALUoutM, PCplusImmM, r2M  out 32  EX/MEM register outputs
//  rdM         out  5   EX/MEM register output
//  strCtrlM    out  3   EX/MEM register output
//  RegWriteM, MemWriteM, MemtoRegM  out 1  EX/MEM register outputs
// BEHAVIOUR
//  - Reset (rst==0 at a clock edge): all *M outputs 0, FSM to IDLE, busyE 0, divider regs 0. This also applies mid-divide: the operation is aborted with no result.
//  - ALUCtrlE encoding: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB,
//    11 MUL, 12 MULH, 13 MULHSU, 14 MULHU, 15 DIV, 16 DIVU, 17 REM, 18 REMU. Codes 19-31 produce 0.
//    Shift amount is srcBE[4:0]. MUL returns the low 32 bits of the 64-bit product; MULH* return the high 32 bits with the per-op signedness.
//  - Non-divide ops: latency 1. On each edge with validE=1 and flushE=0, the EX/MEM register loads result, PCE+ImmE, r2E, rdE, strCtrlE and the control bits.
//  - A bubble is RegWriteM=0, MemWriteM=0, MemtoRegM=0, with the other M fields unchanged. A bubble is loaded when validE=0, flushE=1, or busyE=1.
//  - Divider FSM, states IDLE, RUN, DONE:
//    IDLE: validE & divide op & !flushE -> latch |A|, |B|, signs, op.
//      B==0 or (signed op & A==0x80000000 & B==0xFFFFFFFF) -> DONE (fast path).
//      Otherwise -> RUN with counter = N_ITER-1. busyE=1 in this cycle.
//    RUN: restoring division, DIV_BITS_PER_CYCLE bits per cycle. busyE=1. Counter reaching 0 -> DONE.
//    DONE: busyE=0. Sign-corrected result goes to ALUoutM with the instruction's fields at this edge. Next state IDLE.
//  - Total busy cycles: N_ITER+1 on the normal path, 1 on the fast path. Result is visible at the M outputs after the DONE edge.
//  - Corner-case results:
//    divide by zero: quotient 0xFFFFFFFF, remainder = dividend.
//    signed overflow: quotient 0x80000000, remainder 0.
//    Signed results: quotient negated if sA^sB, remainder negated if sA.
//  - flushE=1 in any state: bubble into MEM, FSM to IDLE, busyE deasserts next cycle; no result is written. flushE has priority over a divide start.
//  - ID/EX inputs are stable while busyE=1. The unit re-reads the instruction fields in DONE, not the latched operands.
//  - Back-to-back divides: DONE->IDLE then start next cycle; there is one cycle of busyE=0 between them.
// TESTING
//  1. rst=0 for 2 cycles mid-traffic -> all M outputs 0, busyE 0; after release, ADD 5+7 -> ALUoutM=12 one edge later.
//  2. SUB 3-5, SRA 0x80000000>>>4, SLTU 1<0xFFFFFFFF -> 0xFFFFFFFE, 0xF8000000, 1; PCplusImmM=PCE+ImmE.
//  3. MULH 0xFFFFFFFF*0xFFFFFFFF -> 0; MULHU same -> 0xFFFFFFFE; MUL 0x10000*0x10000 -> 0.
//  4. DIV -7/2 -> -3 and REM -7/2 -> -1: busyE high exactly 33 cycles (DIV_BITS_PER_CYCLE=1), RegWriteM=0 during them.
//  5. DIVU 10/0 -> 0xFFFFFFFF; REM 10/0 -> 10; DIV 0x80000000/-1 -> 0x80000000: each with busyE high 1 cycle.
//  6. flushE at RUN cycle 10 -> bubble, FSM IDLE, no write; repeat the test with rst=0 mid-RUN -> outputs 0, busyE 0.

Source files
------------

// File: rtl/execute_stage_if.sv
// ID/EX -> EX/MEM bundle for the execute stage.
// master: ID side + MEM consumer; slave: execute stage.
interface execute_stage_if;
  logic        validE;
  logic        flushE;
  logic [4:0]  ALUCtrlE;
  logic [31:0] srcAE;
  logic [31:0] srcBE;
  logic [31:0] r2E;
  logic [31:0] PCE;
  logic [31:0] ImmE;
  logic [4:0]  rdE;
  logic [2:0]  strCtrlE;
  logic        RegWriteE;
  logic        MemWriteE;
  logic        MemtoRegE;
  logic        busyE;
  logic [31:0] ALUoutM;
  logic [31:0] PCplusImmM;
  logic [31:0] r2M;
  logic [4:0]  rdM;
  logic [2:0]  strCtrlM;
  logic        RegWriteM;
  logic        MemWriteM;
  logic        MemtoRegM;

  modport master (
    output validE, flushE, ALUCtrlE, srcAE, srcBE, r2E,
    output PCE, ImmE, rdE, strCtrlE,
    output RegWriteE, MemWriteE, MemtoRegE,
    input  busyE, ALUoutM, PCplusImmM, r2M, rdM, strCtrlM,
    input  RegWriteM, MemWriteM, MemtoRegM
  );

  modport slave (
    input  validE, flushE, ALUCtrlE, srcAE, srcBE, r2E,
    input  PCE, ImmE, rdE, strCtrlE,
    input  RegWriteE, MemWriteE, MemtoRegE,
    output busyE, ALUoutM, PCplusImmM, r2M, rdM, strCtrlM,
    output RegWriteM, MemWriteM, MemtoRegM
  );
endinterface

// File: rtl/execute_stage.sv
// RV32IM execute stage: ALU, MUL*, iterative divider
// and the EX/MEM pipeline register.
module execute_stage #(
  parameter int DIV_BITS_PER_CYCLE = 1
) (
  input  logic           clk,
  input  logic           rst,
  execute_stage_if.slave bus
);
  localparam int N_ITER = 32 / DIV_BITS_PER_CYCLE;
  localparam logic [4:0] CNT_INIT = 5'(N_ITER - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [31:0] r_quo;
  logic [31:0] r_rem;
  logic [31:0] r_div;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_isrem;

  logic [31:0] r_alu_m;
  logic [31:0] r_pci_m;
  logic [31:0] r_r2_m;
  logic [4:0]  r_rd_m;
  logic [2:0]  r_str_m;
  logic        r_rw_m;
  logic        r_mw_m;
  logic        r_m2r_m;

  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [4:0]  w_op;
  logic [63:0] w_pss;
  logic [63:0] w_psu;
  logic [63:0] w_puu;
  logic [31:0] w_alu;
  logic        w_isdiv;
  logic        w_sgn;
  logic        w_sa;
  logic        w_sb;
  logic [31:0] w_absa;
  logic [31:0] w_absb;
  logic        w_start;
  logic        w_busy;
  logic        w_fast;
  logic [31:0] w_quo_n;
  logic [31:0] w_rem_n;
  logic [32:0] w_sh;
  logic [32:0] w_diff;
  logic [31:0] w_divres;

  assign w_a  = bus.srcAE;
  assign w_b  = bus.srcBE;
  assign w_op = bus.ALUCtrlE;

  assign w_pss = {{32{w_a[31]}}, w_a} * {{32{w_b[31]}}, w_b};
  assign w_psu = {{32{w_a[31]}}, w_a} * {32'd0, w_b};
  assign w_puu = {32'd0, w_a} * {32'd0, w_b};

  // Single-cycle ALU / multiplier result
  always_comb begin
    w_alu = '0;
    unique case (w_op)
      5'd0:    w_alu = w_a + w_b;
      5'd1:    w_alu = w_a - w_b;
      5'd2:    w_alu = w_a << w_b[4:0];
      5'd3:    w_alu = {31'd0, $signed(w_a) < $signed(w_b)};
      5'd4:    w_alu = {31'd0, w_a < w_b};
      5'd5:    w_alu = w_a ^ w_b;
      5'd6:    w_alu = w_a >> w_b[4:0];
      5'd7:    w_alu = $signed(w_a) >>> w_b[4:0];
      5'd8:    w_alu = w_a | w_b;
      5'd9:    w_alu = w_a & w_b;
      5'd10:   w_alu = w_b;
      5'd11:   w_alu = w_pss[31:0];
      5'd12:   w_alu = w_pss[63:32];
      5'd13:   w_alu = w_psu[63:32];
      5'd14:   w_alu = w_puu[63:32];
      default: w_alu = '0;
    endcase
  end

  assign w_isdiv = (w_op >= 5'd15) && (w_op <= 5'd18);
  assign w_sgn   = (w_op == 5'd15) || (w_op == 5'd17);
  assign w_sa    = w_sgn & w_a[31];
  assign w_sb    = w_sgn & w_b[31];
  assign w_absa  = w_sa ? -w_a : w_a;
  assign w_absb  = w_sb ? -w_b : w_b;
  assign w_fast  = (w_b == 32'd0) ||
                   (w_sgn && w_a == 32'h8000_0000 &&
                    w_b == 32'hFFFF_FFFF);

  assign w_start = (r_state == S_IDLE) & bus.validE &
                   w_isdiv & ~bus.flushE;
  assign w_busy  = rst & (w_start | (r_state == S_RUN));
  assign bus.busyE = w_busy;

  // Restoring-division steps retired in one RUN cycle
  always_comb begin
    w_rem_n = r_rem;
    w_quo_n = r_quo;
    w_sh    = '0;
    w_diff  = '0;
    for (int i = 0; i < DIV_BITS_PER_CYCLE; i++) begin
      w_sh   = {w_rem_n, w_quo_n[31]};
      w_diff = w_sh - {1'b0, r_div};
      if (!w_diff[32]) begin
        w_rem_n = w_diff[31:0];
        w_quo_n = {w_quo_n[30:0], 1'b1};
      end else begin
        w_rem_n = w_sh[31:0];
        w_quo_n = {w_quo_n[30:0], 1'b0};
      end
    end
  end

  assign w_divres = r_isrem ?
    (r_neg_r ? -r_rem : r_rem) :
    (r_neg_q ? -r_quo : r_quo);

  // Divider FSM: IDLE -> (RUN) -> DONE -> IDLE
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_div   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_isrem <= 1'b0;
    end else if (bus.flushE) begin
      r_state <= S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_start) begin
          r_isrem <= (w_op == 5'd17) || (w_op == 5'd18);
          if (w_fast) begin
            r_quo   <= (w_b == 32'd0) ? 32'hFFFF_FFFF
                                      : 32'h8000_0000;
            r_rem   <= (w_b == 32'd0) ? w_a : 32'd0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_quo   <= w_absa;
            r_rem   <= '0;
            r_div   <= w_absb;
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
            r_cnt   <= CNT_INIT;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_quo <= w_quo_n;
          r_rem <= w_rem_n;
          if (r_cnt == 5'd0) r_state <= S_DONE;
          else r_cnt <= r_cnt - 5'd1;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // EX/MEM register: result, bubble or reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_alu_m <= '0;
      r_pci_m <= '0;
      r_r2_m  <= '0;
      r_rd_m  <= '0;
      r_str_m <= '0;
      r_rw_m  <= 1'b0;
      r_mw_m  <= 1'b0;
      r_m2r_m <= 1'b0;
    end else if (bus.flushE || !bus.validE || w_busy) begin
      r_rw_m  <= 1'b0;
      r_mw_m  <= 1'b0;
      r_m2r_m <= 1'b0;
    end else begin
      r_alu_m <= (r_state == S_DONE) ? w_divres : w_alu;
      r_pci_m <= bus.PCE + bus.ImmE;
      r_r2_m  <= bus.r2E;
      r_rd_m  <= bus.rdE;
      r_str_m <= bus.strCtrlE;
      r_rw_m  <= bus.RegWriteE;
      r_mw_m  <= bus.MemWriteE;
      r_m2r_m <= bus.MemtoRegE;
    end
  end

  assign bus.ALUoutM    = r_alu_m;
  assign bus.PCplusImmM = r_pci_m;
  assign bus.r2M        = r_r2_m;
  assign bus.rdM        = r_rd_m;
  assign bus.strCtrlM   = r_str_m;
  assign bus.RegWriteM  = r_rw_m;
  assign bus.MemWriteM  = r_mw_m;
  assign bus.MemtoRegM  = r_m2r_m;
endmodule

// File: tb/tb_execute_stage.sv
// Directed-vector bench for execute_stage
// (ALU, MUL*, divider timing, flush and reset).
module tb_execute_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  execute_stage_if ifc();

  execute_stage #(.DIV_BITS_PER_CYCLE(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [4:0]  c,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] pc);
    ifc.validE    = 1'b1;
    ifc.flushE    = 1'b0;
    ifc.ALUCtrlE  = c;
    ifc.srcAE     = a;
    ifc.srcBE     = b;
    ifc.r2E       = b;
    ifc.PCE       = pc;
    ifc.ImmE      = 32'h20;
    ifc.rdE       = 5'd7;
    ifc.strCtrlE  = 3'd2;
    ifc.RegWriteE = 1'b1;
    ifc.MemWriteE = 1'b0;
    ifc.MemtoRegE = 1'b0;
  endtask

  task automatic alu(input string tag, input logic [4:0] c,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp);
    set_op(c, a, b, 32'h100);
    step();
    chk(tag, ifc.ALUoutM, exp);
  endtask

  task automatic div(input string tag, input logic [4:0] c,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int nb);
    int cnt;
    logic rw;
    set_op(c, a, b, 32'h200);
    #1;
    cnt = 0;
    rw  = 1'b0;
    while (ifc.busyE && cnt < 100) begin
      cnt++;
      step();
      if (ifc.RegWriteM) rw = 1'b1;
    end
    chk({tag, " busy"}, 32'(cnt), 32'(nb));
    chk({tag, " bubble"}, {31'd0, rw}, 32'd0);
    step();
    chk(tag, ifc.ALUoutM, exp);
    chk({tag, " rw"}, {31'd0, ifc.RegWriteM}, 32'd1);
    ifc.validE = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    set_op(5'd0, 32'd0, 32'd0, 32'd0);
    ifc.validE = 1'b0;
    step();
    step();
    rst = 1'b1;
    chk("rst alu", ifc.ALUoutM, 32'd0);
    chk("rst busy", {31'd0, ifc.busyE}, 32'd0);

    alu("add 1+1", 5'd0, 32'd1, 32'd1, 32'd2);
    set_op(5'd0, 32'd9, 32'd9, 32'h300);
    rst = 1'b0;
    step();
    step();
    chk("mid rst alu", ifc.ALUoutM, 32'd0);
    chk("mid rst pci", ifc.PCplusImmM, 32'd0);
    chk("mid rst rd", {27'd0, ifc.rdM}, 32'd0);
    chk("mid rst rw", {31'd0, ifc.RegWriteM}, 32'd0);
    chk("mid rst busy", {31'd0, ifc.busyE}, 32'd0);
    rst = 1'b1;
    alu("add 5+7", 5'd0, 32'd5, 32'd7, 32'd12);

    alu("sub", 5'd1, 32'd3, 32'd5, 32'hFFFF_FFFE);
    chk("pc+imm", ifc.PCplusImmM, 32'h120);
    chk("r2", ifc.r2M, 32'd5);
    alu("sra", 5'd7, 32'h8000_0000, 32'd4, 32'hF800_0000);
    alu("sltu", 5'd4, 32'd1, 32'hFFFF_FFFF, 32'd1);
    alu("slt", 5'd3, 32'd1, 32'hFFFF_FFFF, 32'd0);
    alu("sll", 5'd2, 32'd1, 32'd31, 32'h8000_0000);
    alu("srl", 5'd6, 32'h8000_0000, 32'd4, 32'h0800_0000);
    alu("passb", 5'd10, 32'd1, 32'hABCD, 32'hABCD);
    alu("bad op", 5'd20, 32'd1, 32'd2, 32'd0);

    alu("mulh", 5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    alu("mulhu", 5'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        32'hFFFF_FFFE);
    alu("mul", 5'd11, 32'h1_0000, 32'h1_0000, 32'd0);
    alu("mulhsu", 5'd13, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);

    div("div -7/2", 5'd15, -32'sd7, 32'd2, 32'hFFFF_FFFD, 33);
    div("rem -7/2", 5'd17, -32'sd7, 32'd2, 32'hFFFF_FFFF, 33);
    div("divu 100/7", 5'd16, 32'd100, 32'd7, 32'd14, 33);
    div("remu 100/7", 5'd18, 32'd100, 32'd7, 32'd2, 33);
    div("divu /0", 5'd16, 32'd10, 32'd0, 32'hFFFF_FFFF, 1);
    div("rem /0", 5'd17, 32'd10, 32'd0, 32'd10, 1);
    div("div ovf", 5'd15, 32'h8000_0000, 32'hFFFF_FFFF,
        32'h8000_0000, 1);

    set_op(5'd16, 32'd100, 32'd7, 32'h400);
    step();
    repeat (9) step();
    chk("flush pre busy", {31'd0, ifc.busyE}, 32'd1);
    ifc.flushE = 1'b1;
    step();
    ifc.flushE = 1'b0;
    ifc.validE = 1'b0;
    #1;
    chk("flush busy", {31'd0, ifc.busyE}, 32'd0);
    chk("flush rw", {31'd0, ifc.RegWriteM}, 32'd0);
    chk("flush alu", ifc.ALUoutM, 32'h8000_0000);
    repeat (3) step();
    chk("flush late rw", {31'd0, ifc.RegWriteM}, 32'd0);
    chk("flush late alu", ifc.ALUoutM, 32'h8000_0000);

    set_op(5'd15, 32'd100, 32'd7, 32'h500);
    step();
    repeat (9) step();
    rst = 1'b0;
    ifc.validE = 1'b0;
    step();
    chk("run rst alu", ifc.ALUoutM, 32'd0);
    chk("run rst pci", ifc.PCplusImmM, 32'd0);
    chk("run rst busy", {31'd0, ifc.busyE}, 32'd0);
    rst = 1'b1;
    repeat (3) step();
    chk("run rst late rw", {31'd0, ifc.RegWriteM}, 32'd0);
    chk("run rst late busy", {31'd0, ifc.busyE}, 32'd0);
    alu("add after", 5'd0, 32'd5, 32'd7, 32'd12);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
